// File: rtl/mem_dump_unit_pkg.sv
// Shared constants and state encoding for the debug memory dump unit.
package mem_dump_unit_pkg;

  localparam int INST_SZ_D      = 32;
  localparam int MEM_SZ_D       = 5;
  localparam int BYTE_SZ_D      = 8;
  localparam int BYTES_PER_WORD = INST_SZ_D / BYTE_SZ_D;
  localparam int BIDX_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } dump_state_e;

  // A single-byte word still needs a one-bit index register.
  function automatic int idx_width(input int bytes_per_word);
    return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
  endfunction

endpackage

// File: rtl/mem_dump_unit_if.sv
// Debug-port and UART-TX handshake bundle between the dump unit (master)
// and the memory stage / transmitter it serves (slave).
interface mem_dump_unit_if
  import mem_dump_unit_pkg::*;
#(
  parameter int INST_SZ = INST_SZ_D,
  parameter int MEM_SZ  = MEM_SZ_D,
  parameter int BYTE_SZ = BYTE_SZ_D
);

  logic [MEM_SZ-1:0]  debug_addr;
  logic [INST_SZ-1:0] debug_mem;
  logic [BYTE_SZ-1:0] tx_data;
  logic               tx_start;
  logic               tx_done;

  modport master (
    output debug_addr,
    output tx_data,
    output tx_start,
    input  debug_mem,
    input  tx_done
  );

  modport slave (
    input  debug_addr,
    input  tx_data,
    input  tx_start,
    output debug_mem,
    output tx_done
  );

endinterface

// File: rtl/mem_dump_unit.sv
// Sweeps every data-memory word through the debug port and streams each word,
// least-significant byte first, to the UART transmitter.
module mem_dump_unit
  import mem_dump_unit_pkg::*;
#(
  parameter int INST_SZ = INST_SZ_D,
  parameter int MEM_SZ  = MEM_SZ_D,
  parameter int BYTE_SZ = BYTE_SZ_D
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  mem_dump_unit_if.master dbg,
  output logic            o_busy,
  output logic            o_done
);

  localparam int BPW   = INST_SZ / BYTE_SZ;
  localparam int IDX_W = idx_width(BPW);

  dump_state_e        r_state;
  dump_state_e        w_state_nxt;
  logic [MEM_SZ-1:0]  r_addr;
  logic [IDX_W-1:0]   r_idx;
  logic [INST_SZ-1:0] r_word;
  logic               w_last_byte;
  logic               w_last_word;

  assign w_last_byte = (r_idx == IDX_W'(BPW - 1));
  assign w_last_word = (r_addr == {MEM_SZ{1'b1}});

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; tx_done only matters while waiting on a byte.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_LOAD;
        else         w_state_nxt = ST_IDLE;
      end
      ST_LOAD: w_state_nxt = ST_SEND;
      ST_SEND: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!dbg.tx_done)     w_state_nxt = ST_WAIT;
        else if (!w_last_byte) w_state_nxt = ST_SEND;
        else if (w_last_word)  w_state_nxt = ST_DONE;
        else                   w_state_nxt = ST_LOAD;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address, byte index and word capture; the word is sampled once, in LOAD.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr <= {MEM_SZ{1'b0}};
      r_idx  <= {IDX_W{1'b0}};
      r_word <= {INST_SZ{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_addr <= {MEM_SZ{1'b0}};
          r_idx  <= {IDX_W{1'b0}};
        end
        ST_LOAD: begin
          r_word <= dbg.debug_mem;
          r_idx  <= {IDX_W{1'b0}};
        end
        ST_WAIT: begin
          if (dbg.tx_done) begin
            if (!w_last_byte) begin
              r_idx <= r_idx + IDX_W'(1);
            end else if (!w_last_word) begin
              r_addr <= r_addr + MEM_SZ'(1);
            end else begin
              r_addr <= r_addr;
            end
          end else begin
            r_idx <= r_idx;
          end
        end
        default: begin
          r_addr <= r_addr;
        end
      endcase
    end
  end

  assign dbg.debug_addr = r_addr;
  assign dbg.tx_data    = r_word[r_idx*BYTE_SZ +: BYTE_SZ];
  assign dbg.tx_start   = (r_state == ST_SEND);
  assign o_busy         = (r_state != ST_IDLE);
  assign o_done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed bench for mem_dump_unit: a memory model with word k = A0B0C0D0+k
// and a UART TX model with configurable done latency.
module tb_mem_dump_unit;
  import mem_dump_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] mem_noise = 32'h0000_0000;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [7:0] rx_q[$];
  logic [4:0] addr_q[$];
  int         tx_cnt     = 0;
  int         tx_delay   = 3;
  bit         early_mode = 1'b0;
  logic [7:0] cur_byte   = 8'h00;
  int         hold_bad   = 0;
  int         done_cnt   = 0;
  int         done_cyc   = 0;

  mem_dump_unit_if bus ();

  // Memory content is garbled while a byte is in flight, so only a LOAD capture is correct.
  assign bus.debug_mem = (32'hA0B0_C0D0 + {27'd0, bus.debug_addr}) ^ mem_noise;

  mem_dump_unit dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_start (start),
    .dbg     (bus.master),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // UART TX model: records each byte on tx_start, answers tx_done after tx_delay cycles.
  always @(negedge clk) begin
    bus.tx_done = 1'b0;
    if (rst === 1'b1) begin
      tx_cnt = 0;
    end else begin
      if (tx_cnt > 0) begin
        tx_cnt = tx_cnt - 1;
        if (tx_cnt == 0) begin
          bus.tx_done = 1'b1;
          done_cyc    = cyc;
          if (bus.tx_data !== cur_byte) hold_bad = hold_bad + 1;
        end
      end
      if (bus.tx_start === 1'b1) begin
        rx_q.push_back(bus.tx_data);
        addr_q.push_back(bus.debug_addr);
        cur_byte = bus.tx_data;
        tx_cnt   = tx_delay;
        if (early_mode) bus.tx_done = 1'b1;
      end
    end
    mem_noise = (tx_cnt > 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
  end

  // Counts o_done pulses.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass = n_pass + 1;
  endtask

  function automatic logic [7:0] exp_byte(input int j);
    logic [31:0] w;
    w = 32'hA0B0_C0D0 + 32'(j / 4);
    return w[(j % 4) * 8 +: 8];
  endfunction

  // Starts a dump at the current negedge (DUT idle) and checks it end to end.
  task automatic run_dump(input int delay, input bit early, input bit poke,
                          input string tag, output int base);
    int nb, bad, dbase, hbase;
    bit poked, seen;
    base  = rx_q.size();
    dbase = done_cnt;
    hbase = hold_bad;
    tx_delay   = delay;
    early_mode = early;
    poked = 1'b0;
    seen  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_load_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_load_addr"}, 32'(bus.debug_addr), 32'd0);
    check_eq({tag, "_load_no_start"}, 32'(bus.tx_start), 32'd0);
    @(negedge clk);
    check_eq({tag, "_send_start"}, 32'(bus.tx_start), 32'd1);
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else if (poke && !poked && busy && bus.debug_addr == 5'd5) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) check_eq({tag, "_done_latency"}, cyc, done_cyc + 1);
    @(negedge clk);
    check_eq({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check_eq({tag, "_done_count"}, done_cnt - dbase, 32'd1);
    check_eq({tag, "_data_hold_errs"}, hold_bad - hbase, 32'd0);
    if (poke) check_eq({tag, "_poke_applied"}, 32'(poked), 32'd1);
    nb = rx_q.size() - base;
    check_eq({tag, "_byte_count"}, nb, 32'd128);
    bad = -1;
    for (int j = 0; j < nb && j < 128; j++) begin
      if (bad < 0 && (rx_q[base+j] !== exp_byte(j) || addr_q[base+j] !== 5'(j / 4))) bad = j;
    end
    check_eq({tag, "_first_bad_index"}, bad, 32'hFFFF_FFFF);
    if (nb > 0) check_eq({tag, "_last_byte"}, 32'(rx_q[rx_q.size()-1]), 32'h0000_00A0);
  endtask

  initial begin
    int b1, b2, b3, n_start, n_busy, n_addr, diff, dbase, k;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_addr", 32'(bus.debug_addr), 32'd0);
    check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check_eq("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    n_start = 0; n_busy = 0; n_addr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.tx_start !== 1'b0) n_start++;
      if (busy !== 1'b0)         n_busy++;
      if (bus.debug_addr !== 5'd0) n_addr++;
    end
    check_eq("idle_tx_start_pulses", n_start, 32'd0);
    check_eq("idle_busy_cycles", n_busy, 32'd0);
    check_eq("idle_addr_nonzero", n_addr, 32'd0);

    run_dump(3, 1'b0, 1'b0, "full", b1);
    run_dump(2, 1'b1, 1'b0, "early_done", b1);
    run_dump(3, 1'b0, 1'b1, "start_while_busy", b1);

    // Reset during the first WAIT cycle of word 10, byte 2.
    tx_delay   = 3;
    early_mode = 1'b0;
    b1    = rx_q.size();
    dbase = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while ((rx_q.size() - b1) < 43 && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("rst_reach_w10b2", rx_q.size() - b1, 32'd43);
    @(negedge clk);
    check_eq("rst_pre_addr", 32'(bus.debug_addr), 32'd10);
    check_eq("rst_pre_data", 32'(bus.tx_data), 32'h0000_00B0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_addr", 32'(bus.debug_addr), 32'd0);
    check_eq("midrst_tx_data", 32'(bus.tx_data), 32'd0);
    check_eq("midrst_tx_start", 32'(bus.tx_start), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_no_done", done_cnt - dbase, 32'd0);

    run_dump(3, 1'b0, 1'b0, "after_rst", b2);
    run_dump(3, 1'b0, 1'b0, "back_to_back", b3);
    diff = 0;
    for (int j = 0; j < 128; j++) begin
      if (b2 + j >= rx_q.size() || b3 + j >= rx_q.size()) diff++;
      else if (rx_q[b2+j] !== rx_q[b3+j]) diff++;
    end
    check_eq("b2b_identical_diffs", diff, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
